// File: rtl/uart_tx_serializer_pkg.sv
// Shared UART definitions for the FIR UART path: state encoding, default line settings and the
// clocks-per-bit helper used by the transmitter, the matching receiver and the FIR top level.
package uart_tx_serializer_pkg;

  localparam int unsigned DefaultClkFreq = 50_000_000;
  localparam int unsigned DefaultBaud    = 115_200;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } uart_state_e;

  // Rounded clocks per bit; callers must keep the result >= 2.
  function automatic int unsigned calc_div(input int unsigned clk_freq, input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Byte handshake between the FIR control unit (master) and the UART transmitter (slave).
interface uart_tx_serializer_if;

  logic       TxD_start;
  logic [7:0] TxD_data;
  logic       TxD;
  logic       TxD_busy;

  modport master (
    output TxD_start,
    output TxD_data,
    input  TxD,
    input  TxD_busy
  );

  modport slave (
    input  TxD_start,
    input  TxD_data,
    output TxD,
    output TxD_busy
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts Div clocks and flags the last clock of each period.
// restart reloads the count so the next period is exactly Div clocks long.
module uart_baud_tick #(
  parameter int unsigned Div = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] Reload = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart || (cnt_q == '0)) begin
      cnt_d = Reload;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter, 8N1 LSB first, one byte per TxD_start while idle; registered TxD line.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module uart_tx_serializer
  import uart_tx_serializer_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DefaultClkFreq,
  parameter int unsigned BAUD     = DefaultBaud
) (
  input logic                  clk,
  input logic                  reset,
  uart_tx_serializer_if.slave  tx
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD);

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q;
  logic [2:0]  bit_cnt_q;
  logic        txd_q, txd_d;
  logic        busy;
  logic        accept;
  logic        tick;
`ifdef UART_TX_PARITY_EN
  logic        parity_q;
`endif

  assign accept = (state_q == StIdle) && tx.TxD_start;

  uart_baud_tick #(
    .Div (DIV)
  ) u_baud_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (accept),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (tx.TxD_start) state_d = StStart;
      StStart:  if (tick) state_d = StData;
      StData: begin
        if (tick && (bit_cnt_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_d = StParity;
`else
          state_d = StStop;
`endif
        end
      end
      StParity: if (tick) state_d = StStop;
      StStop:   if (tick) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Line level is decoded from the current state and registered, so TxD trails state by a clock.
  always_comb begin
    txd_d = 1'b1;
    busy  = (state_q != StIdle);
    unique case (state_q)
      StIdle:   txd_d = 1'b1;
      StStart:  txd_d = 1'b0;
      StData:   txd_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      StParity: txd_d = parity_q;
`else
      StParity: txd_d = 1'b1;
`endif
      StStop:   txd_d = 1'b1;
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      txd_q     <= 1'b1;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      txd_q <= txd_d;
      if (accept) begin
        shift_q   <= tx.TxD_data;
        bit_cnt_q <= 3'd0;
`ifdef UART_TX_PARITY_EN
        parity_q  <= ^tx.TxD_data;
`endif
      end else if ((state_q == StData) && tick) begin
        shift_q   <= {1'b0, shift_q[7:1]};
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
    end
  end

  assign tx.TxD      = txd_q;
  assign tx.TxD_busy = busy;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer at DIV = 4; frame layout depends on UART_TX_PARITY_EN.
module tb_uart_tx_serializer;

  localparam int Div = 4;
`ifdef UART_TX_PARITY_EN
  localparam int Slots = 11;
`else
  localparam int Slots = 10;
`endif
  localparam int FrameLen = Slots * Div;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  uart_tx_serializer_if tx_if ();

  uart_tx_serializer #(
    .CLK_FREQ (400),
    .BAUD     (100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .tx    (tx_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Entered #1 after the accepting edge; checks every clock of the frame up to busy falling.
  task automatic run_frame(input string tag, input logic [7:0] d, input int poke_at,
                           input logic poke_start, input logic [7:0] poke_data,
                           input logic hold);
    logic       exp_txd;
    logic [2:0] bi;
    chk({tag, " busy@accept"}, tx_if.TxD_busy, 1'b1);
    chk({tag, " txd@accept"}, tx_if.TxD, 1'b1);
    if (!hold) tx_if.TxD_start = 1'b0;
    for (int i = 1; i <= FrameLen; i++) begin
      tick();
      if (i <= 4) begin
        exp_txd = 1'b0;
      end else if (i <= 36) begin
        bi      = 3'((i - 5) / 4);
        exp_txd = d[bi];
      end else if ((Slots == 11) && (i <= 40)) begin
        exp_txd = ^d;
      end else begin
        exp_txd = 1'b1;
      end
      chk($sformatf("%s txd c%0d", tag, i), tx_if.TxD, exp_txd);
      chk($sformatf("%s busy c%0d", tag, i), tx_if.TxD_busy, (i < FrameLen));
      if (i == poke_at) begin
        tx_if.TxD_start = poke_start;
        tx_if.TxD_data  = poke_data;
      end else if ((i == poke_at + 1) && !hold) begin
        tx_if.TxD_start = 1'b0;
      end
    end
  endtask

  task automatic chk_idle(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      chk($sformatf("%s txd %0d", tag, k), tx_if.TxD, 1'b1);
      chk($sformatf("%s busy %0d", tag, k), tx_if.TxD_busy, 1'b0);
    end
  endtask

  initial begin
    tx_if.TxD_start = 1'b0;
    tx_if.TxD_data  = 8'h00;
    reset           = 1'b1;
    tick();
    tick();
    chk("reset txd", tx_if.TxD, 1'b1);
    chk("reset busy", tx_if.TxD_busy, 1'b0);
    reset = 1'b0;
    chk_idle("post-reset idle", 2);

    // Single A5 frame with an FF request mid-frame that must be dropped.
    tx_if.TxD_start = 1'b1;
    tx_if.TxD_data  = 8'hA5;
    tick();
    run_frame("a5", 8'hA5, 10, 1'b1, 8'hFF, 1'b0);
    chk_idle("after a5", 4);

    // Start held high: 3C then C3 with one idle clock between frames.
    tx_if.TxD_start = 1'b1;
    tx_if.TxD_data  = 8'h3C;
    tick();
    run_frame("3c", 8'h3C, 1, 1'b1, 8'hC3, 1'b1);
    tick();
    run_frame("c3", 8'hC3, -1, 1'b0, 8'h00, 1'b0);
    chk_idle("after c3", 2);

    // Data changed right after acceptance; captured 81 must be sent.
    tx_if.TxD_start = 1'b1;
    tx_if.TxD_data  = 8'h81;
    tick();
    run_frame("81", 8'h81, 1, 1'b0, 8'h00, 1'b0);
    chk_idle("after 81", 2);

    // Odd and even popcounts for the parity slot.
    tx_if.TxD_start = 1'b1;
    tx_if.TxD_data  = 8'h07;
    tick();
    run_frame("07", 8'h07, -1, 1'b0, 8'h00, 1'b0);
    chk_idle("after 07", 1);
    tx_if.TxD_start = 1'b1;
    tx_if.TxD_data  = 8'h03;
    tick();
    run_frame("03", 8'h03, -1, 1'b0, 8'h00, 1'b0);
    chk_idle("after 03", 1);

    // Reset for 3 clocks in the middle of a 5A frame, with start asserted during reset.
    tx_if.TxD_start = 1'b1;
    tx_if.TxD_data  = 8'h5A;
    tick();
    chk("5a busy@accept", tx_if.TxD_busy, 1'b1);
    tx_if.TxD_start = 1'b0;
    repeat (15) tick();
    chk("5a mid-frame bit2", tx_if.TxD, 1'b0);
    reset           = 1'b1;
    tx_if.TxD_start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("reset mid txd %0d", k), tx_if.TxD, 1'b1);
      chk($sformatf("reset mid busy %0d", k), tx_if.TxD_busy, 1'b0);
    end
    reset           = 1'b0;
    tx_if.TxD_start = 1'b0;
    chk_idle("after mid reset", 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
